m_axi_cmd_master: RTL and testbench

- Single-beat AXI3-style master that sits directly upstream of the register slave and drives its AW/W/B and AR/R channels.
- Accepts one command at a time from a simple valid/ready command port: read or write, address, data, strobe, id.
- Runs the AXI handshakes and returns exactly one response word per command on a valid/ready response port.
- Adds an ID/last check and a response timeout, so a hung or misbehaving slave produces an error response instead of a deadlock.

---
 rtl/axi_pkg.sv | 22 ++
 rtl/m_axi_cmd_master_if.sv | 93 +++++++++
 rtl/axi_timeout_cnt.sv | 32 +++
 rtl/m_axi_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_m_axi_cmd_master.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the single-beat AXI command master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int ID_W_DEF   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/m_axi_cmd_master_if.sv
// Bundle of the command port, response port and AXI AW/W/B/AR/R channels.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs of each channel.
interface m_axi_cmd_master_if
    import axi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF
);
    localparam int STRB_W = DATA_W / 8;

    // command port
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [STRB_W-1:0] cmd_wstrb_i;
    logic [ID_W-1:0]   cmd_id_i;

    // response port
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_write_o;
    logic [ID_W-1:0]   rsp_id_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic [1:0]        rsp_resp_o;
    logic              rsp_timeout_o;

    // write address / data / response
    logic [ID_W-1:0]   awid_o;
    logic [ADDR_W-1:0] awaddr_o;
    logic              awvalid_o;
    logic              awready_i;
    logic [ID_W-1:0]   wid_o;
    logic [DATA_W-1:0] wdata_o;
    logic [STRB_W-1:0] wstrb_o;
    logic              wlast_o;
    logic              wvalid_o;
    logic              wready_i;
    logic [ID_W-1:0]   bid_i;
    logic [1:0]        bresp_i;
    logic              bvalid_i;
    logic              bready_o;

    // read address / data
    logic [ID_W-1:0]   arid_o;
    logic [ADDR_W-1:0] araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [ID_W-1:0]   rid_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;
    logic              rvalid_i;
    logic              rready_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, cmd_id_i,
        output cmd_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_write_o, rsp_id_o, rsp_rdata_o, rsp_resp_o, rsp_timeout_o,
        output awid_o, awaddr_o, awvalid_o,
        input  awready_i,
        output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        input  wready_i,
        input  bid_i, bresp_i, bvalid_i,
        output bready_o,
        output arid_o, araddr_o, arvalid_o,
        input  arready_i,
        input  rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
        output rready_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, cmd_id_i,
        input  cmd_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_write_o, rsp_id_o, rsp_rdata_o, rsp_resp_o, rsp_timeout_o,
        input  awid_o, awaddr_o, awvalid_o,
        output awready_i,
        input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        output wready_i,
        output bid_i, bresp_i, bvalid_i,
        input  bready_o,
        input  arid_o, araddr_o, arvalid_o,
        output arready_i,
        output rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
        input  rready_o
    );

endinterface

// File: rtl/axi_timeout_cnt.sv
// Wait counter for B/R beats; flags expiry once TIMEOUT waiting cycles have elapsed.
// Latency: expired is combinational on the last waiting cycle (count == TIMEOUT-1 with en).
// Backpressure: none; clr has priority over en, TIMEOUT=0 never expires.
module axi_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic areset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Expire on the cycle whose increment would make the count reach TIMEOUT.
    assign expired = (TIMEOUT != 0) && en && (cnt_q == LAST);

    // Count waiting cycles; restart whenever the owner leaves its wait state.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/m_axi_cmd_master.sv
// Single-beat AXI master: one command in, AW+W/B or AR/R on the bus, one response word out.
// Latency: 3 cycles accept-to-rsp_valid with an always-ready slave; timeout bounds the B/R wait.
// Backpressure: cmd_ready only in IDLE; response held in RSP until rsp_ready; AXI valids held until ready.
module m_axi_cmd_master
    import axi_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic areset,
    m_axi_cmd_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic [ID_W-1:0]   id;
    } cmd_t;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] rdata;
        logic              timeout;
    } rsp_t;

    state_t state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    rsp_t   rsp_q, rsp_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic awvalid, wvalid, arvalid, bready, rready;
    logic aw_hs, w_hs, beat, wait_st;
    logic tmo_clr, tmo_en, tmo_expired;

    // Channel valids/readies decode straight from state so reset drops them at once.
    assign awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign arvalid = (state_q == RD_REQ);
    assign bready  = (state_q == WR_RESP);
    assign rready  = (state_q == RD_DATA);

    assign aw_hs   = awvalid && bus.awready_i;
    assign w_hs    = wvalid && bus.wready_i;
    assign beat    = (bready && bus.bvalid_i) || (rready && bus.rvalid_i);
    assign wait_st = bready || rready;

    // A beat in the expiring cycle suppresses the timeout because en drops.
    assign tmo_clr = !wait_st;
    assign tmo_en  = wait_st && !beat;

    axi_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .areset  (areset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Next state plus command/response/progress register updates.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rsp_d     = rsp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    cmd_d.wr    = bus.cmd_write_i;
                    cmd_d.addr  = bus.cmd_addr_i;
                    cmd_d.wdata = bus.cmd_wdata_i;
                    cmd_d.wstrb = bus.cmd_wstrb_i;
                    cmd_d.id    = bus.cmd_id_i;
                    rsp_d       = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = bus.cmd_write_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.bvalid_i) begin
                    rsp_d.resp = (bus.bid_i == cmd_q.id) ? bus.bresp_i : RESP_SLVERR;
                    state_d    = RSP;
                end else if (tmo_expired) begin
                    rsp_d.resp    = RESP_SLVERR;
                    rsp_d.rdata   = '0;
                    rsp_d.timeout = 1'b1;
                    state_d       = RSP;
                end
            end
            RD_REQ: begin
                if (bus.arready_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.rvalid_i) begin
                    rsp_d.rdata = bus.rdata_i;
                    rsp_d.resp  = ((bus.rid_i == cmd_q.id) && bus.rlast_i) ? bus.rresp_i
                                                                         : RESP_SLVERR;
                    state_d     = RSP;
                end else if (tmo_expired) begin
                    rsp_d.resp    = RESP_SLVERR;
                    rsp_d.rdata   = '0;
                    rsp_d.timeout = 1'b1;
                    state_d       = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured command, response word and AW/W completion flags.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cmd_q     <= '0;
            rsp_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            rsp_q     <= rsp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign bus.cmd_ready_o   = (state_q == IDLE);

    assign bus.awid_o        = cmd_q.id;
    assign bus.awaddr_o      = cmd_q.addr;
    assign bus.awvalid_o     = awvalid;
    assign bus.wid_o         = cmd_q.id;
    assign bus.wdata_o       = cmd_q.wdata;
    assign bus.wstrb_o       = cmd_q.wstrb;
    assign bus.wlast_o       = 1'b1;
    assign bus.wvalid_o      = wvalid;
    assign bus.bready_o      = bready;
    assign bus.arid_o        = cmd_q.id;
    assign bus.araddr_o      = cmd_q.addr;
    assign bus.arvalid_o     = arvalid;
    assign bus.rready_o      = rready;

    assign bus.rsp_valid_o   = (state_q == RSP);
    assign bus.rsp_write_o   = cmd_q.wr;
    assign bus.rsp_id_o      = cmd_q.id;
    assign bus.rsp_rdata_o   = rsp_q.rdata;
    assign bus.rsp_resp_o    = rsp_q.resp;
    assign bus.rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_m_axi_cmd_master.sv
// Bench for m_axi_cmd_master: directed commands against a configurable AXI slave.
// Latency: a transaction-level model predicts every handshake cycle and response word.
// Backpressure: slave ready delays, withheld B, and delayed rsp_ready are exercised.
module tb_m_axi_cmd_master;

    localparam int TO = 8;

    logic clk;
    logic areset;

    m_axi_cmd_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    m_axi_cmd_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .ID_W    (4),
        .TIMEOUT (TO)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave configuration ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit          b_en = 1, r_en = 1;
    logic [3:0]  s_bid = 0, s_rid = 0;
    logic [1:0]  s_bresp = 0, s_rresp = 0;
    logic [31:0] s_rdata = 0;
    logic        s_rlast = 1;

    // Slave: ready after a per-channel delay, B/R offered whenever the master is ready.
    initial begin
        int awc = 0, wc = 0, arc = 0;
        bus.awready_i = 0; bus.wready_i = 0; bus.arready_i = 0;
        bus.bvalid_i = 0; bus.bid_i = 0; bus.bresp_i = 0;
        bus.rvalid_i = 0; bus.rid_i = 0; bus.rdata_i = 0; bus.rresp_i = 0; bus.rlast_i = 0;
        forever begin
            @(posedge clk); #1;
            awc = bus.awvalid_o ? awc + 1 : 0;
            wc  = bus.wvalid_o  ? wc + 1  : 0;
            arc = bus.arvalid_o ? arc + 1 : 0;
            bus.awready_i = bus.awvalid_o && (awc > aw_dly);
            bus.wready_i  = bus.wvalid_o  && (wc > w_dly);
            bus.arready_i = bus.arvalid_o && (arc > ar_dly);
            bus.bvalid_i  = b_en && bus.bready_o;
            bus.bid_i     = s_bid;
            bus.bresp_i   = s_bresp;
            bus.rvalid_i  = r_en && bus.rready_o;
            bus.rid_i     = s_rid;
            bus.rdata_i   = s_rdata;
            bus.rresp_i   = s_rresp;
            bus.rlast_i   = s_rlast;
        end
    end

    // ---------------- transaction model ----------------
    bit          busy = 0, m_wr = 0, aw_seen = 0, w_seen = 0, ar_seen = 0, rsp_known = 0;
    bit          wt_b, wt_r, exp_rv;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_strb = 0, m_id = 0;
    logic [1:0]  e_resp = 0;
    logic [31:0] e_rdata = 0;
    bit          e_to = 0;
    int          wait_cyc = 0, cyc = 0, acc_cyc = 0;
    int          aw_first = -1, b_first = -1, rsp_first = -1;
    int          aw_cnt_v = 0, w_cnt_v = 0, rsp_hold = 0, b_hs_cnt = 0;

    // Compare every output against the model once per cycle, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (areset) begin
            busy = 0;
            rsp_known = 0;
            chk("rst_cmd_ready", bus.cmd_ready_o, 1);
            chk("rst_valids", {bus.awvalid_o, bus.wvalid_o, bus.arvalid_o,
                               bus.bready_o, bus.rready_o, bus.rsp_valid_o}, 0);
        end else begin
            wt_b   = busy && m_wr && aw_seen && w_seen && !rsp_known;
            wt_r   = busy && !m_wr && ar_seen && !rsp_known;
            exp_rv = busy && rsp_known;
            chk("cmd_ready", bus.cmd_ready_o, !busy);
            chk("awvalid",   bus.awvalid_o, busy && m_wr && !aw_seen);
            chk("wvalid",    bus.wvalid_o,  busy && m_wr && !w_seen);
            chk("arvalid",   bus.arvalid_o, busy && !m_wr && !ar_seen);
            chk("bready",    bus.bready_o,  wt_b);
            chk("rready",    bus.rready_o,  wt_r);
            chk("rsp_valid", bus.rsp_valid_o, exp_rv);
            if (bus.awvalid_o) begin
                chk("awaddr", bus.awaddr_o, m_addr);
                chk("awid",   bus.awid_o,   m_id);
            end
            if (bus.wvalid_o) begin
                chk("wdata", bus.wdata_o, m_wdata);
                chk("wstrb", bus.wstrb_o, m_strb);
                chk("wid",   bus.wid_o,   m_id);
                chk("wlast", bus.wlast_o, 1);
            end
            if (bus.arvalid_o) begin
                chk("araddr", bus.araddr_o, m_addr);
                chk("arid",   bus.arid_o,   m_id);
            end
            if (bus.rsp_valid_o && exp_rv) begin
                chk("rsp_write",   bus.rsp_write_o,   m_wr);
                chk("rsp_id",      bus.rsp_id_o,      m_id);
                chk("rsp_rdata",   bus.rsp_rdata_o,   e_rdata);
                chk("rsp_resp",    bus.rsp_resp_o,    e_resp);
                chk("rsp_timeout", bus.rsp_timeout_o, e_to);
            end
            if (bus.awvalid_o) begin aw_cnt_v++; if (aw_first < 0) aw_first = cyc; end
            if (bus.wvalid_o) w_cnt_v++;
            if (bus.bready_o && b_first < 0) b_first = cyc;
            if (bus.rsp_valid_o) begin rsp_hold++; if (rsp_first < 0) rsp_first = cyc; end

            if (!busy) begin
                if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                    busy = 1; m_wr = bus.cmd_write_i; m_addr = bus.cmd_addr_i;
                    m_wdata = bus.cmd_wdata_i; m_strb = bus.cmd_wstrb_i; m_id = bus.cmd_id_i;
                    aw_seen = 0; w_seen = 0; ar_seen = 0; rsp_known = 0; wait_cyc = 0;
                    acc_cyc = cyc; aw_first = -1; b_first = -1; rsp_first = -1;
                    aw_cnt_v = 0; w_cnt_v = 0; rsp_hold = 0; b_hs_cnt = 0;
                end
            end else begin
                if (wt_b || wt_r) begin
                    if (wt_b && bus.bvalid_i) begin
                        rsp_known = 1; b_hs_cnt++; e_rdata = 0; e_to = 0;
                        e_resp = (bus.bid_i == m_id) ? bus.bresp_i : 2'b10;
                    end else if (wt_r && bus.rvalid_i) begin
                        rsp_known = 1; e_rdata = bus.rdata_i; e_to = 0;
                        e_resp = (bus.rid_i == m_id && bus.rlast_i) ? bus.rresp_i : 2'b10;
                    end else begin
                        wait_cyc++;
                        if (wait_cyc == TO) begin
                            rsp_known = 1; e_resp = 2'b10; e_rdata = 0; e_to = 1;
                        end
                    end
                end
                if (m_wr && bus.awvalid_o && bus.awready_i) aw_seen = 1;
                if (m_wr && bus.wvalid_o && bus.wready_i) w_seen = 1;
                if (!m_wr && bus.arvalid_o && bus.arready_i) ar_seen = 1;
                if (exp_rv && bus.rsp_valid_o && bus.rsp_ready_i) busy = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0]  got_resp;
    logic [31:0] got_rdata;
    logic [3:0]  got_id;
    logic        got_write, got_to;

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] id);
        int n = 0;
        @(posedge clk); #2;
        bus.cmd_write_i = wr; bus.cmd_addr_i = a; bus.cmd_wdata_i = d;
        bus.cmd_wstrb_i = s; bus.cmd_id_i = id; bus.cmd_valid_i = 1;
        @(negedge clk);
        while (!bus.cmd_ready_o && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept_wait", bus.cmd_ready_o, 1);
        @(posedge clk); #2;
        bus.cmd_valid_i = 0;
    endtask

    task automatic recv_rsp(input int dly);
        int n = 0;
        bus.rsp_ready_i = (dly == 0);
        @(negedge clk);
        while (!bus.rsp_valid_o && n < 60) begin @(negedge clk); n++; end
        chk("rsp_wait", bus.rsp_valid_o, 1);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #2 bus.rsp_ready_i = 1;
            @(negedge clk);
        end
        got_resp = bus.rsp_resp_o; got_rdata = bus.rsp_rdata_o; got_id = bus.rsp_id_o;
        got_write = bus.rsp_write_o; got_to = bus.rsp_timeout_o;
        @(posedge clk); #2;
        bus.rsp_ready_i = 0;
    endtask

    initial begin
        areset = 1;
        bus.cmd_valid_i = 0; bus.cmd_write_i = 0; bus.cmd_addr_i = 0;
        bus.cmd_wdata_i = 0; bus.cmd_wstrb_i = 0; bus.cmd_id_i = 0; bus.rsp_ready_i = 0;
        #1;
        chk("reset_cmd_ready", bus.cmd_ready_o, 1);
        chk("reset_awvalid",   bus.awvalid_o, 0);
        chk("reset_rsp_valid", bus.rsp_valid_o, 0);
        chk("reset_awaddr",    bus.awaddr_o, 0);
        chk("reset_rsp_id",    bus.rsp_id_o, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata_o, 0);
        repeat (3) @(posedge clk);
        #2 areset = 0;

        // 1: basic write, always-ready slave
        s_bid = 5; s_bresp = 0;
        send_cmd(1, 32'h3, 32'hDEADBEEF, 4'hF, 4'h5);
        recv_rsp(0);
        chk("t1_resp", got_resp, 2'b00);
        chk("t1_write", got_write, 1);
        chk("t1_id", got_id, 4'h5);
        chk("t1_rdata", got_rdata, 0);
        chk("t1_aw_lat", aw_first - acc_cyc, 1);
        chk("t1_rsp_lat", rsp_first - acc_cyc, 3);

        // 2: awready delayed 4 cycles, wready immediate
        aw_dly = 4; s_bid = 2;
        send_cmd(1, 32'h40, 32'h0000A5A5, 4'h3, 4'h2);
        recv_rsp(0);
        chk("t2_aw_cycles", aw_cnt_v, 5);
        chk("t2_w_cycles", w_cnt_v, 1);
        chk("t2_b_beats", b_hs_cnt, 1);
        chk("t2_resp", got_resp, 2'b00);
        chk("t2_rsp_lat", rsp_first - acc_cyc, 7);
        aw_dly = 0;

        // 3: read, response held 3 cycles before rsp_ready
        s_rid = 7; s_rdata = 32'h12345678; s_rresp = 0; s_rlast = 1;
        send_cmd(0, 32'h2, 32'h0, 4'h0, 4'h7);
        recv_rsp(3);
        chk("t3_rdata", got_rdata, 32'h12345678);
        chk("t3_resp", got_resp, 2'b00);
        chk("t3_write", got_write, 0);
        chk("t3_hold", rsp_hold, 4);
        chk("t3_rsp_lat", rsp_first - acc_cyc, 3);

        // 4: read with wrong rid
        s_rid = 6; s_rdata = 32'hCAFE0001;
        send_cmd(0, 32'h8, 32'h0, 4'h0, 4'h7);
        recv_rsp(0);
        chk("t4_resp", got_resp, 2'b10);
        chk("t4_timeout", got_to, 0);
        chk("t4_rdata", got_rdata, 32'hCAFE0001);

        // 5: read with rlast low
        s_rid = 7; s_rlast = 0; s_rdata = 32'h0BADF00D;
        send_cmd(0, 32'hC, 32'h0, 4'h0, 4'h7);
        recv_rsp(0);
        chk("t5_resp", got_resp, 2'b10);
        chk("t5_timeout", got_to, 0);
        s_rlast = 1;

        // 6: write with wrong bid
        s_bid = 1;
        send_cmd(1, 32'h20, 32'h11112222, 4'h1, 4'h9);
        recv_rsp(0);
        chk("t6_resp", got_resp, 2'b10);
        chk("t6_timeout", got_to, 0);

        // 7: write whose B never arrives
        b_en = 0;
        send_cmd(1, 32'h24, 32'h33334444, 4'hF, 4'h4);
        recv_rsp(0);
        chk("t7_resp", got_resp, 2'b10);
        chk("t7_timeout", got_to, 1);
        chk("t7_rdata", got_rdata, 0);
        chk("t7_wait", rsp_first - b_first, 8);
        chk("t7_rsp_lat", rsp_first - acc_cyc, 10);
        chk("t7_bready_after", bus.bready_o, 0);
        b_en = 1;

        // 8: reset pulse while AW and W are both pending
        aw_dly = 20; w_dly = 20;
        send_cmd(1, 32'h10, 32'h55, 4'h1, 4'hA);
        repeat (2) @(posedge clk);
        #2 chk("t8_aw_before", bus.awvalid_o, 1);
        #1 areset = 1;
        #1;
        chk("t8_awvalid", bus.awvalid_o, 0);
        chk("t8_wvalid", bus.wvalid_o, 0);
        chk("t8_cmd_ready", bus.cmd_ready_o, 1);
        chk("t8_rsp_valid", bus.rsp_valid_o, 0);
        @(posedge clk); #2 areset = 0;
        aw_dly = 0; w_dly = 0; s_bid = 4'hC; s_bresp = 0;
        send_cmd(1, 32'h30, 32'h77778888, 4'hF, 4'hC);
        recv_rsp(0);
        chk("t8_next_resp", got_resp, 2'b00);
        chk("t8_next_id", got_id, 4'hC);
        chk("t8_next_lat", rsp_first - acc_cyc, 3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, expected completion");
        $fatal(1);
    end

endmodule
